uart_rx_buf: RTL

Serial receive side of the core's UART link: deserializes 8-bit frames from the `rx` pin and buffers them in a small FIFO. It presents the `uart_empty` / `uart_in` / `uart_rdreq` pop interface that the CPU's memory-mapped UART read path consumes. It is the producer end of that interface; the CPU is the consumer.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_fifo.sv | 75 +++++++
 rtl/uart_rx_buf.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing with a PARITY state).
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO for received bytes. Owns the pointers, the
// occupancy count, the full/empty flags and the overrun pulse.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic                  empty,
  output logic [DATA_W-1:0]     head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  logic [DEPTH_LOG2:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2:0] rptr_q, rptr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic                overrun_q, overrun_d;
  logic                full;
  logic                pop_ok;
  logic                push_ok;

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]) &&
                   (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]);
  assign count   = wptr_q - rptr_q;
  assign head    = empty ? '0 : mem_q[rptr_q[DEPTH_LOG2-1:0]];
  assign overrun = overrun_q;

  // A pop frees the slot a same-cycle push lands in, so push is allowed when full if popping.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Next-state for pointers, storage and the overrun pulse.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    mem_d     = mem_q;
    overrun_d = push & full & ~pop_ok;
    if (pop_ok) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    if (push_ok) begin
      mem_d[wptr_q[DEPTH_LOG2-1:0]] = push_data;
      wptr_d = wptr_q + PTR_ONE;
    end
  end

  // Control state: pointers and pulse are reset; the byte storage is not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      overrun_q <= overrun_d;
    end
  end

  // Byte storage; contents are only observable through valid pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_rx_buf.sv
// UART receiver with byte FIFO: 2-flop synchronizer, frame FSM, shift register
// and a show-ahead FIFO exposing the uart_empty / uart_in / uart_rdreq pop port.
// Optional feature macro: UART_RX_PARITY_EN (8E1 with even parity check; else 8N1).
module uart_rx_buf
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  input  logic                  uart_rdreq,
  output logic                  uart_empty,
  output logic [7:0]            uart_in,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic                  overrun,
  output logic                  frame_err,
  output logic                  parity_err
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = 1;
  localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic                      sync1_q, sync2_q, rx_prev_q;
  logic                      rx_s;
  rx_state_e                 state_q, state_d;
  logic [BAUD_W-1:0]         baud_q, baud_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      frame_err_q, frame_err_d;
  logic                      tick;
  logic                      push;
`ifdef UART_RX_PARITY_EN
  logic                      parity_bad_q, parity_bad_d;
  logic                      parity_err_q, parity_err_d;
`endif

  assign rx_s = sync2_q;
  assign tick = (baud_q == '0);

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; idle-high reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // Frame FSM: every sample is taken when the baud counter reaches zero (mid-bit).
  always_comb begin
    state_d     = state_q;
    baud_d      = tick ? baud_q : baud_q - BAUD_ONE;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = ST_START;
          baud_d  = BAUD_HALF;
        end
      end
      ST_START: begin
        if (tick) begin
          if (!rx_s) begin
            state_d   = ST_DATA;
            baud_d    = BAUD_FULL;
            bit_cnt_d = '0;
          end else begin
            // Line was high at mid-start-bit: treat as a glitch.
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_d   = {rx_s, shreg_q[UART_DATA_BITS-1:1]};
          baud_d    = BAUD_FULL;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          // Even parity: parity bit equals XOR of the data bits.
          parity_bad_d = rx_s ^ (^shreg_q);
          baud_d       = BAUD_FULL;
          state_d      = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          // Return to IDLE mid-stop-bit so a back-to-back start edge is not missed.
          state_d = ST_IDLE;
          if (!rx_s) begin
            frame_err_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          else if (parity_bad_q) begin
            parity_err_d = 1'b1;
          end
`endif
          else begin
            push = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM control registers and error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      baud_q       <= '0;
      bit_cnt_q    <= '0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Data shift register; never observed outside a completed frame, so not reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  uart_rx_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (UART_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shreg_q),
    .pop       (uart_rdreq),
    .empty     (uart_empty),
    .head      (uart_in),
    .count     (rx_count),
    .overrun   (overrun)
  );

endmodule
